// File: rtl/jt51_lin2exp_mc_if.sv
// ---------------------------------------------------------------------------
// jt51_lin2exp_mc_if
// Stream bundle for the multi-channel linear-to-exponent converter.
//   Input side : in_valid / in_ready handshake carrying one frame of CH
//                signed LIN_W-bit samples (channel c at [c*LIN_W +: LIN_W]).
//   Output side: out_valid / out_ready handshake carrying one converted
//                sample per beat: out_man (signed mantissa), out_exp
//                (1..EMAX), out_ch (channel index), out_last (channel CH-1).
// Modports:
//   slave  - the converter (consumes frames, produces samples)
//   master - the environment (produces frames, consumes samples)
// ---------------------------------------------------------------------------
interface jt51_lin2exp_mc_if #(
    parameter int LIN_W = 16,
    parameter int MAN_W = 10,
    parameter int EXP_W = 3,
    parameter int CH    = 2
);
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [CH*LIN_W-1:0]   in_lin;

    logic                  out_valid;
    logic                  out_ready;
    logic [MAN_W-1:0]      out_man;
    logic [EXP_W-1:0]      out_exp;
    logic [CH_W-1:0]       out_ch;
    logic                  out_last;

    modport slave (
        input  in_valid, in_lin, out_ready,
        output in_ready, out_valid, out_man, out_exp, out_ch, out_last
    );

    modport master (
        output in_valid, in_lin, out_ready,
        input  in_ready, out_valid, out_man, out_exp, out_ch, out_last
    );
endinterface

// File: rtl/jt51_lin2exp_mc.sv
// ---------------------------------------------------------------------------
// jt51_lin2exp_mc
// Pipelined multi-channel linear-to-floating-point converter for the JT51
// output path. A frame of CH signed samples is captured in one handshake and
// then issued one channel per cycle through two pipeline stages:
//   stage 1 : count redundant sign bits, clamp to EMAX-1, register
//   stage 2 : shift, slice mantissa, form exponent EMAX-S (output register)
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset (sync release expected)
//   io_bus - jt51_lin2exp_mc_if.slave stream bundle (see interface file)
// Build option:
//   JT51_LIN2EXP_ROUND_EN - when defined, stage 2 rounds half-up on the
//   discarded bits instead of truncating; positive overflow saturates.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a frame, in_ready=1
// ST_ISSUE | pushing channel r_cnt into stage 1 each non-stalled cycle
// ---------------------------------------------------------------------------
module jt51_lin2exp_mc #(
    parameter int LIN_W = 16,
    parameter int MAN_W = 10,
    parameter int EXP_W = 3,
    parameter int CH    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jt51_lin2exp_mc_if.slave     io_bus
);
    localparam int EMAX = LIN_W - MAN_W + 1;
    localparam int SMAX = EMAX - 1;
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
    localparam int LZ_W = $clog2(LIN_W);

    if (MAN_W < 2 || MAN_W >= LIN_W) begin : g_bad_man_w
        $error("jt51_lin2exp_mc: MAN_W must satisfy 2 <= MAN_W < LIN_W");
    end
    if ((1 << EXP_W) - 1 < EMAX) begin : g_bad_exp_w
        $error("jt51_lin2exp_mc: EXP_W too narrow for EMAX");
    end
    if (CH < 1) begin : g_bad_ch
        $error("jt51_lin2exp_mc: CH must be at least 1");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CH_W-1:0]     r_cnt, w_cnt_nxt;
    logic [CH*LIN_W-1:0] r_frame;
    logic                w_accept;
    logic                w_push;
    logic                w_stall;

    logic                r_s1_valid;
    logic [LIN_W-1:0]    r_s1_lin;
    logic [EXP_W-1:0]    r_s1_shift;
    logic [CH_W-1:0]     r_s1_ch;

    logic                r_out_valid;
    logic [MAN_W-1:0]    r_out_man;
    logic [EXP_W-1:0]    r_out_exp;
    logic [CH_W-1:0]     r_out_ch;
    logic                r_out_last;

    logic [LIN_W-1:0]    w_sel;
    logic [LZ_W-1:0]     w_lead;
    logic                w_run;
    logic [EXP_W-1:0]    w_shift;
    logic [EXP_W-1:0]    w_rsh;
    logic [MAN_W-1:0]    w_man;

    // A bubble in the output register never stalls the pipeline.
    assign w_stall = r_out_valid & ~io_bus.out_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_frame <= io_bus.in_lin;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!w_stall) begin
                    w_push = 1'b1;
                    if (r_cnt == CH_W'(CH - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CH_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign io_bus.in_ready = (r_state == ST_IDLE);

    // ---------------- Stage 1: redundant sign bit count ----------------
    assign w_sel = r_frame[int'(r_cnt) * LIN_W +: LIN_W];

    always_comb begin
        w_run  = 1'b1;
        w_lead = '0;
        for (int i = LIN_W - 2; i >= 0; i--) begin
            if (w_run && (w_sel[i] == w_sel[LIN_W-1])) begin
                w_lead = w_lead + LZ_W'(1);
            end else begin
                w_run = 1'b0;
            end
        end
        w_shift = (w_lead > LZ_W'(SMAX)) ? EXP_W'(SMAX) : EXP_W'(w_lead);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_lin   <= '0;
            r_s1_shift <= '0;
            r_s1_ch    <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_push;
            if (w_push) begin
                r_s1_lin   <= w_sel;
                r_s1_shift <= w_shift;
                r_s1_ch    <= r_cnt;
            end
        end
    end

    // ---------------- Stage 2: mantissa / exponent ----------------
    // Right-shifting by (EMAX-1-S) places lin[LIN_W-1-S -: MAN_W] at the
    // bottom; S never exceeds EMAX-1, so the amount is never negative.
    assign w_rsh = EXP_W'(SMAX) - r_s1_shift;

`ifdef JT51_LIN2EXP_ROUND_EN
    logic [MAN_W:0]   w_ext;
    logic [MAN_W-1:0] w_trunc;
    logic             w_sat;

    // An appended zero below the LSB becomes the round bit; at S=EMAX-1 it
    // is the only discarded bit, so nothing gets rounded there.
    assign w_ext   = (MAN_W+1)'({r_s1_lin, 1'b0} >> w_rsh);
    assign w_trunc = w_ext[MAN_W:1];
    // Only the largest positive mantissa can overflow when incremented.
    assign w_sat   = ~w_trunc[MAN_W-1] & (&w_trunc[MAN_W-2:0]);
    assign w_man   = (w_ext[0] & ~w_sat) ? (w_trunc + MAN_W'(1)) : w_trunc;
`else
    assign w_man   = MAN_W'(r_s1_lin >> w_rsh);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_man   <= '0;
            r_out_exp   <= '0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_man  <= w_man;
                r_out_exp  <= EXP_W'(EMAX) - r_s1_shift;
                r_out_ch   <= r_s1_ch;
                r_out_last <= (r_s1_ch == CH_W'(CH - 1));
            end
        end
    end

    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_man   = r_out_man;
    assign io_bus.out_exp   = r_out_exp;
    assign io_bus.out_ch    = r_out_ch;
    assign io_bus.out_last  = r_out_last;

endmodule

// File: doc/jt51_lin2exp_mc.md
Name: jt51_lin2exp_mc

Overview:
- Parametrised, pipelined, multi-channel linear-to-floating-point converter for the JT51 output path (DAC/serial-data stage).
- Accepts one frame of CH signed linear samples in parallel. Converts them one channel per cycle into a signed mantissa plus a sign-redundancy exponent, emitted over a valid/ready stream.
- Generalises the fixed 16→10+3 combinational converter: configurable widths, channel count, handshake with backpressure, optional rounding.

Parameters:
- LIN_W, 16, signed linear input width.
- MAN_W, 10, signed mantissa width. Must satisfy 2 ≤ MAN_W < LIN_W.
- EXP_W, 3, exponent width. Must satisfy 2^EXP_W − 1 ≥ EMAX, where EMAX = LIN_W − MAN_W + 1 (7 by default).
- CH, 2, channels per frame, ≥1.

Ports:
- clk, in, 1, system clock (rising edge).
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, frame valid.
- in_ready, out, 1, frame accepted when in_valid & in_ready.
- in_lin, in, CH*LIN_W, channel c at bits [c*LIN_W +: LIN_W], two's complement.
- out_valid, out, 1, converted sample valid.
- out_ready, in, 1, sink accepts when out_valid & out_ready.
- out_man, out, MAN_W, signed mantissa.
- out_exp, out, EXP_W, exponent, range 1..EMAX.
- out_ch, out, clog2(CH) (min 1), channel index of the sample.
- out_last, out, 1, high with channel CH−1.

Behaviour:
- Reset (async assert, sync release) clears all of the following: state=IDLE, channel counter=0, both pipeline valids=0, out_valid=0, out_man=0, out_exp=0, out_ch=0, out_last=0, captured frame=0. in_ready=1 after reset.
- FSM:
  - IDLE: in_ready=1. On accept, capture in_lin into the frame register, set counter=0, go to ISSUE.
  - ISSUE: in_ready=0. Each non-stalled cycle, push channel[counter] into stage 1 and increment the counter. After pushing CH−1, return to IDLE.
  - in_ready is a pure function of state.
- Stage 1: compute R = the number of leading bits equal to the sign bit, excluding the sign bit itself, counted from bit LIN_W−2 down. Register shift S = min(R, EMAX−1), the sample and the channel index.
- Stage 2 (output register):
  - exp = EMAX − S.
  - man = lin[LIN_W−1−S −: MAN_W], i.e. truncation.
- Stall: stall = out_valid & ~out_ready. On stall, stage 1, stage 2, the FSM counter and the frame register all hold. A bubble in stage 2 (out_valid=0) never causes a stall.
- Latency: a frame accepted at edge k gives channel c out_valid after edge k+2+c, with no stalls. Throughput is CH samples per CH+1 cycles. A new frame may be accepted while the pipeline drains.
- Output stability: out_* stay constant while out_valid & ~out_ready.
- Boundaries:
  - All-zero and all-ones inputs give S=EMAX−1 and exp=1.
  - The most-negative input gives exp=EMAX and man = 1 followed by zeros.
  - CH=1: out_ch=0 and out_last=1 for every sample.
  - Reset mid-frame discards all in-flight samples and produces no partial output.

Optional Feature:
- Macro: JT51_LIN2EXP_ROUND_EN.
- Defined:
  - Stage 2 rounds half-up on the discarded bits lin[EMAX−1−S−1:0] (LSB weight 1/2 of a mantissa LSB). There is nothing to round when S=EMAX−1.
  - If rounding would overflow the positive mantissa, man saturates to 0 followed by ones and exp is unchanged.
  - Negative values never overflow.
  - Latency is unchanged.
- Undefined: pure truncation as described above.

Test Plan:
- Reset, frame {16'h4000, 16'h0000}, out_ready=1 → ch0 man=10'h100 exp=7; ch1 man=0 exp=1 last=1. Outputs appear at cycles k+2 and k+3.
- Frame {16'h0400, 16'h8000} → ch0 exp=3 man=10'h100; ch1 exp=7 man=10'h200.
- Frame {16'hFFFF, 16'h0123} → ch0 exp=1 man=10'h3FF; ch1 exp=1 man=10'h123.
- out_ready=0 for 5 cycles after ch0 appears → ch0 held stable, no loss or duplication, in_ready stays low until issue completes. Then both channels arrive in order.
- Back-to-back frames with in_valid held high → second accept occurs the cycle after the first frame's last issue; 4 outputs in order, 1-cycle gap between frames.
- ROUND_EN: 16'h0402 → man=10'h101 exp=3 (truncate build: 10'h100). 16'h7FFF → man=10'h1FF exp=7 (saturated). Additionally, assert rst_n mid-frame → out_valid=0 immediately and in_ready=1.
